// File: rtl/exec_sequencer_pkg.sv
// Shared definitions for the 3-bit program machine: opcodes, sequencer
// state encoding and the default instruction-pointer width.
package exec_sequencer_pkg;

  localparam int IP_W_DEF = 4;

  typedef enum logic [2:0] {
    OP_ADV = 3'd0,
    OP_BXL = 3'd1,
    OP_BST = 3'd2,
    OP_JNZ = 3'd3,
    OP_BXC = 3'd4,
    OP_OUT = 3'd5,
    OP_BDV = 3'd6,
    OP_CDV = 3'd7
  } opcode_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_EXEC  = 2'd2,
    ST_DONE  = 2'd3
  } seq_state_e;

  function automatic logic is_jnz(input logic [2:0] op);
    return opcode_e'(op) == OP_JNZ;
  endfunction

endpackage

// File: rtl/exec_sequencer_step_guard.sv
// step_guard: counts executed instructions since the last start and flags
// the exec_done that would bring the count to MAX_STEPS.
module step_guard
  import exec_sequencer_pkg::*;
#(
  parameter int MAX_STEPS = 1024
) (
  input  logic clk,
  input  logic rstn,
  input  logic clear,
  input  logic step,
  output logic limit_hit
);

  localparam int CW = $clog2(MAX_STEPS + 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)      cnt <= '0;
    else if (clear) cnt <= '0;
    else if (step)  cnt <= cnt + CW'(1);
  end

  // Flag in the same cycle as the step so the sequencer can terminate on it.
  assign limit_hit = step && (cnt == CW'(MAX_STEPS - 1));

endmodule

// File: rtl/exec_sequencer.sv
// exec_sequencer: owns the instruction pointer, freezes/unfreezes fetch, hands
// opcodes to the execute unit and resolves jnz / end-of-program.
// Build option: STEP_LIMIT_EN adds an instruction budget of MAX_STEPS (step_err).
module exec_sequencer
  import exec_sequencer_pkg::*;
#(
  parameter int IP_W      = IP_W_DEF,
  parameter int MAX_STEPS = 1024
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            start,
  input  logic            abort,
  input  logic [IP_W:0]   prog_len,
  input  logic [2:0]      opcode,
  input  logic [2:0]      operand,
  input  logic            a_nonzero,
  input  logic            exec_done,
  output logic [IP_W-1:0] instr_ptr,
  output logic            halt,
  output logic            exec_en,
  output logic            busy,
  output logic            done,
  output logic [IP_W:0]   final_ip,
  output logic            step_err
);

  seq_state_e      state, state_nxt;
  logic [IP_W-1:0] ip;
  logic [IP_W:0]   next_ip, done_ip, final_ip_q;
  logic [IP_W+1:0] next_ip_p1;
  logic            end_of_prog, limit_hit;
  logic            go_done, ld_zero, ld_next, run_start;
  logic            first_q, done_q;

  // Next ip is formed one bit wider than ip so a step past the last word never wraps.
  always_comb begin
    if (is_jnz(opcode) && a_nonzero) next_ip = (IP_W+1)'(operand);
    else                             next_ip = {1'b0, ip} + (IP_W+1)'(2);
    next_ip_p1  = {1'b0, next_ip} + (IP_W+2)'(1);
    end_of_prog = next_ip_p1 >= {1'b0, prog_len};
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    go_done   = 1'b0;
    done_ip   = '0;
    ld_zero   = 1'b0;
    ld_next   = 1'b0;
    run_start = 1'b0;
    case (state)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          run_start = 1'b1;
          if (prog_len < (IP_W+1)'(2)) begin
            go_done   = 1'b1;
            state_nxt = ST_DONE;
          end else begin
            ld_zero   = 1'b1;
            state_nxt = ST_FETCH;
          end
        end
      end
      ST_FETCH: state_nxt = ST_EXEC;
      ST_EXEC: begin
        if (exec_done) begin
          if (end_of_prog || limit_hit) begin
            go_done   = 1'b1;
            done_ip   = next_ip;
            state_nxt = ST_DONE;
          end else begin
            ld_next   = 1'b1;
            state_nxt = ST_FETCH;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
    // Abort outranks everything, including a same-cycle exec_done.
    if (abort) begin
      state_nxt = ST_IDLE;
      go_done   = 1'b0;
      ld_zero   = 1'b0;
      ld_next   = 1'b0;
      run_start = 1'b0;
    end
  end

  always_comb begin
    halt      = (state != ST_FETCH);
    busy      = (state == ST_FETCH) || (state == ST_EXEC);
    exec_en   = (state == ST_EXEC) && first_q;
    done      = done_q;
    final_ip  = final_ip_q;
    instr_ptr = ip;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ip         <= '0;
      first_q    <= 1'b0;
      done_q     <= 1'b0;
      final_ip_q <= '0;
    end else begin
      first_q <= (state == ST_FETCH) && !abort;
      done_q  <= go_done;
      if (go_done) final_ip_q <= done_ip;
      if (ld_zero || abort) ip <= '0;
      else if (ld_next)     ip <= next_ip[IP_W-1:0];
    end
  end

`ifdef STEP_LIMIT_EN
  logic step, step_err_q;

  assign step = (state == ST_EXEC) && exec_done && !abort;

  step_guard #(.MAX_STEPS(MAX_STEPS)) u_step_guard (
    .clk       (clk),
    .rstn      (rstn),
    .clear     (run_start),
    .step      (step),
    .limit_hit (limit_hit)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)                               step_err_q <= 1'b0;
    else if (run_start)                      step_err_q <= 1'b0;
    else if (go_done && state == ST_EXEC)    step_err_q <= limit_hit;
  end

  assign step_err = step_err_q;
`else
  logic unused_cfg;

  assign limit_hit  = 1'b0;
  assign step_err   = 1'b0;
  assign unused_cfg = ^(32'(MAX_STEPS));
`endif

endmodule

// File: tb/tb_exec_sequencer.sv
// Scoreboard bench for exec_sequencer: stimulus pushes expected fetch/done
// events, a negedge monitor pops and compares as the DUT presents them.
module tb_exec_sequencer;
  import exec_sequencer_pkg::*;

  localparam int IP_W = 4;

  logic            clk = 1'b0, rstn = 1'b0, start = 1'b0, abort = 1'b0;
  logic            a_nonzero = 1'b0, exec_done = 1'b0;
  logic [IP_W:0]   prog_len = '0;
  logic [2:0]      opcode = '0, operand = '0;
  logic [IP_W-1:0] instr_ptr;
  logic            halt, exec_en, busy, done, step_err;
  logic [IP_W:0]   final_ip;

  exec_sequencer #(.IP_W(IP_W), .MAX_STEPS(8)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .start     (start),
    .abort     (abort),
    .prog_len  (prog_len),
    .opcode    (opcode),
    .operand   (operand),
    .a_nonzero (a_nonzero),
    .exec_done (exec_done),
    .instr_ptr (instr_ptr),
    .halt      (halt),
    .exec_en   (exec_en),
    .busy      (busy),
    .done      (done),
    .final_ip  (final_ip),
    .step_err  (step_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          is_done;
    logic [IP_W:0] val;
    logic          err;
  } ev_t;

  ev_t  exp_q[$];
  ev_t  mon_e;
  logic [2:0] mem [0:16];
  int   checks = 0, errors = 0, halt_low = 0;
  int   exec_delay = 0, pend_cnt = 0, anz_budget = 0;
  bit   pending = 1'b0;
  int   lat, n, h0;

  // Fetch stage model: registers the word pair while unfrozen.
  always @(posedge clk)
    if (!halt) begin
      opcode  <= mem[{1'b0, instr_ptr}];
      operand <= mem[{1'b0, instr_ptr} + 5'd1];
    end

  // Execute unit model: exec_done after exec_delay extra cycles; a_nonzero per jnz budget.
  always @(negedge clk) begin
    if (exec_done) begin
      exec_done = 1'b0;
      pending   = 1'b0;
    end
    if (exec_en) begin
      pending  = 1'b1;
      pend_cnt = exec_delay;
      if (opcode == 3'd3) begin
        a_nonzero = (anz_budget > 0);
        if (anz_budget > 0) anz_budget--;
      end
    end else if (pending && pend_cnt > 0) begin
      pend_cnt--;
    end
    exec_done = pending && (pend_cnt == 0);
  end

  // Monitor: every unfrozen cycle is a fetch event, every done pulse a done event.
  always @(negedge clk)
    if (rstn) begin
      if (!halt) begin
        halt_low++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL fetch_unexpected: fetch at ip %0d with nothing expected", instr_ptr);
        end else begin
          mon_e = exp_q.pop_front();
          if (mon_e.is_done || mon_e.val != {1'b0, instr_ptr}) begin
            errors++;
            $display("FAIL fetch_ip: got fetch ip %0d, expected %s %0d",
                     instr_ptr, mon_e.is_done ? "done" : "fetch", mon_e.val);
          end
        end
      end
      if (done) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL done_unexpected: done final_ip %0d with nothing expected", final_ip);
        end else begin
          mon_e = exp_q.pop_front();
          if (!mon_e.is_done || mon_e.val != final_ip || mon_e.err != step_err) begin
            errors++;
            $display("FAIL done_event: got done final_ip %0d step_err %0d, expected %s %0d step_err %0d",
                     final_ip, step_err, mon_e.is_done ? "done" : "fetch", mon_e.val, mon_e.err);
          end
        end
      end
    end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic push_f(input int ip);
    ev_t e;
    e.is_done = 1'b0; e.val = (IP_W+1)'(ip); e.err = 1'b0;
    exp_q.push_back(e);
  endtask

  task automatic push_d(input int fip, input logic err);
    ev_t e;
    e.is_done = 1'b1; e.val = (IP_W+1)'(fip); e.err = err;
    exp_q.push_back(e);
  endtask

  // Pulse start for one cycle; returns at the negedge after the sampling edge.
  task automatic kick(input int plen, input int dly);
    prog_len   = (IP_W+1)'(plen);
    exec_delay = dly;
    start      = 1'b1;
    @(negedge clk);
    start      = 1'b0;
  endtask

  // lat = clock edges after the start-sampling edge until done is visible.
  task automatic wait_done(output int l);
    l = 0;
    while (!done && l < 300) begin
      @(negedge clk);
      l++;
    end
    if (!done) chk("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_exec_en();
    int k = 0;
    while (!exec_en && k < 10) begin
      @(negedge clk);
      k++;
    end
    chk("exec_en_seen", 32'(exec_en), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 17; i++) mem[i] = 3'd0;
    repeat (3) @(negedge clk);
    chk("rst_instr_ptr", 32'(instr_ptr), 32'd0);
    chk("rst_halt",      32'(halt),      32'd1);
    chk("rst_exec_en",   32'(exec_en),   32'd0);
    chk("rst_busy",      32'(busy),      32'd0);
    chk("rst_done",      32'(done),      32'd0);
    chk("rst_final_ip",  32'(final_ip),  32'd0);
    chk("rst_step_err",  32'(step_err),  32'd0);
    rstn = 1'b1;
    @(negedge clk);

    // Straight-line program, same-cycle exec_done.
    mem[0] = 3'd2; mem[1] = 3'd4; mem[2] = 3'd1; mem[3] = 3'd1;
    h0 = halt_low;
    push_f(0); push_f(2); push_d(4, 1'b0);
    kick(4, 0);
    wait_done(lat);
    chk("t1_latency",  32'(lat), 32'd4);
    chk("t1_halt_low", 32'(halt_low - h0), 32'd2);
    chk("t1_busy_done", 32'(busy), 32'd0);
    repeat (2) @(negedge clk);

    // jnz back to 0 taken twice, then falls through past the end.
    mem[0] = 3'd1; mem[1] = 3'd2; mem[2] = 3'd5; mem[3] = 3'd6; mem[4] = 3'd3; mem[5] = 3'd0;
    anz_budget = 2;
    for (int p = 0; p < 3; p++) begin push_f(0); push_f(2); push_f(4); end
    push_d(6, 1'b0);
    kick(6, 0);
    wait_done(lat);
    chk("t2_latency", 32'(lat), 32'd18);
    repeat (2) @(negedge clk);

    // Odd length: ip 4 is never fetched; a start while busy is ignored.
    mem[0] = 3'd0; mem[1] = 3'd1; mem[2] = 3'd2; mem[3] = 3'd3; mem[4] = 3'd4;
    push_f(0); push_f(2); push_d(4, 1'b0);
    kick(5, 1);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(lat);
    repeat (2) @(negedge clk);

    // Jump target beyond the program terminates immediately.
    mem[0] = 3'd3; mem[1] = 3'd7;
    anz_budget = 1;
    push_f(0); push_d(7, 1'b0);
    kick(6, 0);
    wait_done(lat);
    chk("t4_latency", 32'(lat), 32'd2);
    repeat (2) @(negedge clk);

    // Single-word program: done without ever unfreezing fetch.
    h0 = halt_low;
    push_d(0, 1'b0);
    kick(1, 0);
    wait_done(lat);
    chk("t4b_latency",  32'(lat), 32'd0);
    chk("t4b_halt_low", 32'(halt_low - h0), 32'd0);
    repeat (2) @(negedge clk);

    // Slow execute: exec_en is a single strobe, fetch stays frozen, opcode stable.
    mem[0] = 3'd6; mem[1] = 3'd5; mem[2] = 3'd1; mem[3] = 3'd2;
    push_f(0); push_f(2); push_d(4, 1'b0);
    kick(4, 3);
    wait_exec_en();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("t5_exec_en_once", 32'(exec_en), 32'd0);
      chk("t5_halt_exec",    32'(halt),    32'd1);
      chk("t5_opcode_hold",  32'(opcode),  32'd6);
    end
    wait_done(lat);
    repeat (2) @(negedge clk);

    // Abort while waiting on exec_done: back to IDLE, no done, final_ip kept.
    push_f(0);
    kick(4, 3);
    wait_exec_en();
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_busy",     32'(busy),      32'd0);
    chk("abort_halt",     32'(halt),      32'd1);
    chk("abort_ip",       32'(instr_ptr), 32'd0);
    chk("abort_final_ip", 32'(final_ip),  32'd4);
    chk("abort_done",     32'(done),      32'd0);
    repeat (6) @(negedge clk);

    // Infinite jnz loop at ip 0.
    mem[0] = 3'd3; mem[1] = 3'd0;
    anz_budget = 1000;
`ifdef STEP_LIMIT_EN
    for (int k = 0; k < 8; k++) push_f(0);
    push_d(0, 1'b1);
    kick(2, 0);
    wait_done(lat);
    chk("t6_latency", 32'(lat), 32'd16);
    @(negedge clk);
    chk("t6_step_err_hold", 32'(step_err), 32'd1);
`else
    for (int k = 0; k < 20; k++) push_f(0);
    kick(2, 0);
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("t6_loop_fetches", 32'(exp_q.size()), 32'd0);
    chk("t6_busy_loop",    32'(busy),     32'd1);
    chk("t6_step_err",     32'(step_err), 32'd0);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("t6_abort_busy", 32'(busy), 32'd0);
`endif
    repeat (4) @(negedge clk);

    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
